// File: rtl/div_arbiter_if.sv
// Request, response and divider-side signals of the shared-divider arbiter.
interface div_arbiter_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned NREQ  = 4,
   parameter int unsigned IDW   = $clog2(NREQ)
);
   logic [NREQ-1:0]       i_req_valid;
   logic [NREQ-1:0]       o_req_ready;
   logic [NREQ*WIDTH-1:0] i_req_num;
   logic [NREQ*WIDTH-1:0] i_req_denom;
   logic                  o_rsp_valid;
   logic                  i_rsp_ready;
   logic [IDW-1:0]        o_rsp_id;
   logic [WIDTH-1:0]      o_rsp_result;
   logic [1:0]            o_rsp_err;
   logic [WIDTH-1:0]      o_div_num;
   logic [WIDTH-1:0]      o_div_denom;
   logic                  o_div_start;
   logic [WIDTH-1:0]      i_div_result;
   logic                  i_div_done;
   logic                  i_div_valid;
   logic                  o_busy;

   // Arbiter side
   modport slave (
      input  i_req_valid, i_req_num, i_req_denom, i_rsp_ready,
             i_div_result, i_div_done, i_div_valid,
      output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_err,
             o_div_num, o_div_denom, o_div_start, o_busy
   );

   // Client / divider side
   modport master (
      output i_req_valid, i_req_num, i_req_denom, i_rsp_ready,
             i_div_result, i_div_done, i_div_valid,
      input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_err,
             o_div_num, o_div_denom, o_div_start, o_busy
   );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one iterative fixed-point divider among NREQ
// requesters; screens divide-by-zero and guards the divider with a timeout.
module div_arbiter #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned QBITS   = 8,
   parameter int unsigned NREQ    = 4,
   parameter int unsigned IDW     = $clog2(NREQ),
   parameter int unsigned TIMEOUT = 64
) (
   input logic          i_clk,
   input logic          i_rst,
   div_arbiter_if.slave bus
);
   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   localparam logic [1:0] ERR_OK   = 2'b00;
   localparam logic [1:0] ERR_DIV0 = 2'b01;
   localparam logic [1:0] ERR_TMO  = 2'b10;

   // Reject configurations the sequencing cannot support
   if (NREQ < 2 || QBITS > WIDTH || TIMEOUT <= WIDTH + 2) begin : g_cfg_check
      $error("div_arbiter: illegal parameter combination");
   end

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] num_q, num_d;
   logic [WIDTH-1:0] denom_q, denom_d;
   logic [IDW-1:0]   id_q, id_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [1:0]       err_q, err_d;

   logic [WIDTH-1:0] req_num_a [NREQ];
   logic [WIDTH-1:0] req_den_a [NREQ];
   logic             grant_vld_c;
   logic [IDW-1:0]   grant_id_c;
   logic [IDW-1:0]   cand;
   logic             tmo_c;
   logic [NREQ-1:0]  req_ready_c;
   logic             div_start_c;

   // Unpack the per-requester operand buses
   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign req_num_a[g] = bus.i_req_num[g*WIDTH +: WIDTH];
      assign req_den_a[g] = bus.i_req_denom[g*WIDTH +: WIDTH];
   end

   // Round-robin scan starting at the pointer
   always_comb begin
      grant_vld_c = 1'b0;
      grant_id_c  = '0;
      cand        = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         cand = IDW'((32'(ptr_q) + k) % NREQ);
         if (!grant_vld_c && bus.i_req_valid[cand]) begin
            grant_vld_c = 1'b1;
            grant_id_c  = cand;
         end
      end
   end

   assign tmo_c = (cnt_q == CW'(TIMEOUT - 1));

   // Next-state and handshake decode
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      num_d       = num_q;
      denom_d     = denom_q;
      id_d        = id_q;
      result_d    = result_q;
      err_d       = err_q;
      req_ready_c = '0;
      div_start_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (grant_vld_c) begin
               req_ready_c[grant_id_c] = 1'b1;
               num_d   = req_num_a[grant_id_c];
               denom_d = req_den_a[grant_id_c];
               id_d    = grant_id_c;
               ptr_d   = (grant_id_c == IDW'(NREQ - 1)) ? '0 : grant_id_c + IDW'(1);
               cnt_d   = '0;
               if (req_den_a[grant_id_c] == '0) begin
                  result_d = '0;
                  err_d    = ERR_DIV0;
                  state_d  = S_RESP;
               end else begin
                  state_d  = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            cnt_d = cnt_q + CW'(1);
            if (tmo_c) begin
               result_d = '0;
               err_d    = ERR_TMO;
               state_d  = S_RESP;
            end else begin
               div_start_c = 1'b1;
               if (bus.i_div_done) state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            cnt_d = cnt_q + CW'(1);
            if (bus.i_div_done) begin
               state_d = S_RESP;
               if (bus.i_div_valid) begin
                  result_d = bus.i_div_result;
                  err_d    = ERR_OK;
               end else begin
                  result_d = '0;
                  err_d    = ERR_TMO;
               end
            end else if (tmo_c) begin
               result_d = '0;
               err_d    = ERR_TMO;
               state_d  = S_RESP;
            end
         end
         S_RESP: begin
            if (bus.i_rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= S_IDLE;
         ptr_q    <= '0;
         cnt_q    <= '0;
         num_q    <= '0;
         denom_q  <= '0;
         id_q     <= '0;
         result_q <= '0;
         err_q    <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         cnt_q    <= cnt_d;
         num_q    <= num_d;
         denom_q  <= denom_d;
         id_q     <= id_d;
         result_q <= result_d;
         err_q    <= err_d;
      end
   end

   assign bus.o_req_ready  = i_rst ? '0 : req_ready_c;
   assign bus.o_div_start  = div_start_c;
   assign bus.o_div_num    = num_q;
   assign bus.o_div_denom  = denom_q;
   assign bus.o_rsp_valid  = (state_q == S_RESP);
   assign bus.o_rsp_id     = id_q;
   assign bus.o_rsp_result = result_q;
   assign bus.o_rsp_err    = err_q;
   assign bus.o_busy       = (state_q != S_IDLE);
endmodule
